// File: rtl/cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// cache_req_arbiter
//
// Shares one single-ported cache controller between two requesters (port 0 =
// fetch, port 1 = load/store). Requests are arbitrated round-robin and only
// one transaction is ever outstanding to the cache. The winning command is
// latched and held on c_* until c_ack, then the result is returned to the
// winning port as a one-cycle done pulse. If no ack arrives within TIMEOUT
// BUSY cycles, the transaction is aborted with err=1.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rN_req/op/addr/wdata          request from port N (held until rN_gnt)
//   rN_gnt                        request accepted (combinational, IDLE only)
//   rN_done/err/rdata             registered completion pulse and result
//   c_req/op/addr/wdata           registered command to cache controller
//   c_ack/c_rdata                 cache completion and read data
// -----------------------------------------------------------------------------
module cache_req_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic              r0_op,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_done,
   output logic              r0_err,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_op,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_done,
   output logic              r1_err,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              c_req,
   output logic              c_op,
   output logic [ADDR_W-1:0] c_addr,
   output logic [DATA_W-1:0] c_wdata,
   input  logic              c_ack,
   input  logic [DATA_W-1:0] c_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Last BUSY cycle value of the wait counter; TIMEOUT is limited to 2..255.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t              state_r, state_s;
   logic                ptr_r, ptr_s;       // tie winner: 0 = port 0, 1 = port 1
   logic                owner_r, owner_s;   // port that owns the current command
   logic                op_r, op_s;
   logic [ADDR_W-1:0]   addr_r, addr_s;
   logic [DATA_W-1:0]   wdata_r, wdata_s;
   logic [7:0]          cnt_r, cnt_s;
   logic                c_req_r, c_req_s;
   logic                done0_r, done0_s, done1_r, done1_s;
   logic                err0_r, err0_s, err1_r, err1_s;
   logic [DATA_W-1:0]   rdata0_r, rdata0_s, rdata1_r, rdata1_s;
   logic                gnt0_s, gnt1_s;
   logic                timeout_s;
   logic [DATA_W-1:0]   result_s;

   // Next-state, grant and result logic for the IDLE/BUSY/DONE controller.
   always_comb begin
      state_s   = state_r;
      ptr_s     = ptr_r;
      owner_s   = owner_r;
      op_s      = op_r;
      addr_s    = addr_r;
      wdata_s   = wdata_r;
      cnt_s     = cnt_r;
      c_req_s   = c_req_r;
      gnt0_s    = 1'b0;
      gnt1_s    = 1'b0;
      // Completion outputs are pulses: cleared unless set this cycle.
      done0_s   = 1'b0;
      done1_s   = 1'b0;
      err0_s    = 1'b0;
      err1_s    = 1'b0;
      rdata0_s  = {DATA_W{1'b0}};
      rdata1_s  = {DATA_W{1'b0}};
      timeout_s = 1'b0;
      // Writes return zero data; aborts also return zero data.
      result_s  = {DATA_W{1'b0}};

      case (state_r)
         ST_IDLE: begin
            c_req_s = 1'b0;
            // Port 0 wins when alone or when the pointer favours it on a tie.
            if (r0_req && (!r1_req || !ptr_r)) begin
               gnt0_s  = 1'b1;
               owner_s = 1'b0;
               op_s    = r0_op;
               addr_s  = r0_addr;
               wdata_s = r0_wdata;
               ptr_s   = 1'b1;
               cnt_s   = 8'd0;
               c_req_s = 1'b1;
               state_s = ST_BUSY;
            end else if (r1_req) begin
               gnt1_s  = 1'b1;
               owner_s = 1'b1;
               op_s    = r1_op;
               addr_s  = r1_addr;
               wdata_s = r1_wdata;
               ptr_s   = 1'b0;
               cnt_s   = 8'd0;
               c_req_s = 1'b1;
               state_s = ST_BUSY;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_BUSY: begin
            // Ack beats a coincident timeout.
            if (c_ack) begin
               if (op_r) begin
                  result_s = {DATA_W{1'b0}};
               end else begin
                  result_s = c_rdata;
               end
            end else begin
               result_s  = {DATA_W{1'b0}};
               timeout_s = (cnt_r == TO_LAST);
            end

            if (c_ack || timeout_s) begin
               c_req_s = 1'b0;
               state_s = ST_DONE;
               if (owner_r) begin
                  done1_s  = 1'b1;
                  err1_s   = timeout_s;
                  rdata1_s = result_s;
               end else begin
                  done0_s  = 1'b1;
                  err0_s   = timeout_s;
                  rdata0_s = result_s;
               end
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end

         ST_DONE: begin
            // Completion pulse is on the outputs now; no grant this cycle.
            c_req_s = 1'b0;
            state_s = ST_IDLE;
         end

         default: begin
            c_req_s = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, command and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         ptr_r    <= 1'b0;
         owner_r  <= 1'b0;
         op_r     <= 1'b0;
         addr_r   <= {ADDR_W{1'b0}};
         wdata_r  <= {DATA_W{1'b0}};
         cnt_r    <= 8'd0;
         c_req_r  <= 1'b0;
         done0_r  <= 1'b0;
         done1_r  <= 1'b0;
         err0_r   <= 1'b0;
         err1_r   <= 1'b0;
         rdata0_r <= {DATA_W{1'b0}};
         rdata1_r <= {DATA_W{1'b0}};
      end else begin
         state_r  <= state_s;
         ptr_r    <= ptr_s;
         owner_r  <= owner_s;
         op_r     <= op_s;
         addr_r   <= addr_s;
         wdata_r  <= wdata_s;
         cnt_r    <= cnt_s;
         c_req_r  <= c_req_s;
         done0_r  <= done0_s;
         done1_r  <= done1_s;
         err0_r   <= err0_s;
         err1_r   <= err1_s;
         rdata0_r <= rdata0_s;
         rdata1_r <= rdata1_s;
      end
   end

   assign r0_gnt   = gnt0_s;
   assign r1_gnt   = gnt1_s;
   assign r0_done  = done0_r;
   assign r1_done  = done1_r;
   assign r0_err   = err0_r;
   assign r1_err   = err1_r;
   assign r0_rdata = rdata0_r;
   assign r1_rdata = rdata1_r;
   assign c_req    = c_req_r;
   assign c_op     = op_r;
   assign c_addr   = addr_r;
   assign c_wdata  = wdata_r;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_req_arbiter
//
// Directed bench for cache_req_arbiter (TIMEOUT = 8). Inputs change 1 time
// unit after each rising edge; outputs are checked 2 units later, well before
// the next edge. Expected values are written out by hand per step.
// -----------------------------------------------------------------------------
module tb_cache_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_req, r0_op, r0_gnt, r0_done, r0_err;
   logic [31:0] r0_addr, r0_wdata, r0_rdata;
   logic        r1_req, r1_op, r1_gnt, r1_done, r1_err;
   logic [31:0] r1_addr, r1_wdata, r1_rdata;
   logic        c_req, c_op, c_ack;
   logic [31:0] c_addr, c_wdata, c_rdata;

   int checks = 0;
   int errors = 0;

   cache_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_op(r0_op), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_op(r1_op), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
      .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_rdata(c_rdata)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      r0_req = 1'b0; r0_op = 1'b0; r0_addr = 32'd0; r0_wdata = 32'd0;
      r1_req = 1'b0; r1_op = 1'b0; r1_addr = 32'd0; r1_wdata = 32'd0;
      c_ack = 1'b0; c_rdata = 32'd0;

      // ---------------- reset state ----------------
      next(); next();
      #2;
      chk("rst_c_req",   32'(c_req),   32'd0);
      chk("rst_c_addr",  c_addr,       32'd0);
      chk("rst_c_wdata", c_wdata,      32'd0);
      chk("rst_r0_done", 32'(r0_done), 32'd0);
      chk("rst_r1_done", 32'(r1_done), 32'd0);
      next();
      rst = 1'b0;

      // ---------------- single read ----------------
      r0_req = 1'b1; r0_op = 1'b0; r0_addr = 32'd64;
      #2;
      chk("rd_r0_gnt", 32'(r0_gnt), 32'd1);
      chk("rd_r1_gnt", 32'(r1_gnt), 32'd0);
      chk("rd_c_req0", 32'(c_req),  32'd0);
      next();
      r0_req = 1'b0; c_ack = 1'b1; c_rdata = 32'd111;
      #2;
      chk("rd_c_req1", 32'(c_req), 32'd1);
      chk("rd_c_addr", c_addr,     32'd64);
      chk("rd_c_op",   32'(c_op),  32'd0);
      next();
      c_ack = 1'b0; c_rdata = 32'd0;
      #2;
      chk("rd_r0_done",  32'(r0_done), 32'd1);
      chk("rd_r0_rdata", r0_rdata,     32'd111);
      chk("rd_r0_err",   32'(r0_err),  32'd0);
      chk("rd_r1_done",  32'(r1_done), 32'd0);
      chk("rd_r1_rdata", r1_rdata,     32'd0);
      chk("rd_c_req2",   32'(c_req),   32'd0);
      next();
      #2;
      chk("rd_r0_done_end", 32'(r0_done), 32'd0);

      // ---------------- simultaneous requests after reset ----------------
      rst = 1'b1;
      next();
      rst = 1'b0;
      r0_req = 1'b1; r0_op = 1'b1; r0_addr = 32'd1088; r0_wdata = 32'd222;
      r1_req = 1'b1; r1_op = 1'b0; r1_addr = 32'd3136;
      #2;
      chk("tie_r0_gnt", 32'(r0_gnt), 32'd1);
      chk("tie_r1_gnt", 32'(r1_gnt), 32'd0);
      next();
      r0_req = 1'b0; c_ack = 1'b1; c_rdata = 32'd85;
      #2;
      chk("tie_c_op",    32'(c_op),   32'd1);
      chk("tie_c_addr",  c_addr,      32'd1088);
      chk("tie_c_wdata", c_wdata,     32'd222);
      chk("tie_busy_r1_gnt", 32'(r1_gnt), 32'd0);
      next();
      c_ack = 1'b0;
      #2;
      chk("tie_wr_done",  32'(r0_done), 32'd1);
      chk("tie_wr_rdata", r0_rdata,     32'd0);
      chk("tie_wr_err",   32'(r0_err),  32'd0);
      chk("tie_done_r1_gnt", 32'(r1_gnt), 32'd0);
      chk("tie_done_r1_done", 32'(r1_done), 32'd0);
      next();
      #2;
      chk("tie_r1_gnt_idle", 32'(r1_gnt), 32'd1);
      next();
      r1_req = 1'b0; c_ack = 1'b1; c_rdata = 32'd333;
      #2;
      chk("tie_c_addr1", c_addr, 32'd3136);
      next();
      c_ack = 1'b0;
      #2;
      chk("tie_r1_done",  32'(r1_done), 32'd1);
      chk("tie_r1_rdata", r1_rdata,     32'd333);
      chk("tie_r0_done",  32'(r0_done), 32'd0);
      next();
      r0_req = 1'b1; r0_op = 1'b0; r1_req = 1'b1;
      #2;
      chk("tie_ptr_back_r0", 32'(r0_gnt), 32'd1);
      chk("tie_ptr_back_r1", 32'(r1_gnt), 32'd0);
      next();
      r0_req = 1'b0; r1_req = 1'b0; c_ack = 1'b1;
      next();
      c_ack = 1'b0;
      next();

      // ---------------- stall hold ----------------
      r1_req = 1'b1; r1_op = 1'b0; r1_addr = 32'd7232;
      #2;
      chk("stall_r1_gnt", 32'(r1_gnt), 32'd1);
      next();
      r1_req = 1'b0; r0_req = 1'b1; r0_addr = 32'd512;
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("stall_c_req",  32'(c_req),  32'd1);
         chk("stall_c_addr", c_addr,      32'd7232);
         chk("stall_r0_gnt", 32'(r0_gnt), 32'd0);
         next();
      end
      c_ack = 1'b1; c_rdata = 32'd444;
      #2;
      chk("stall_ack_c_req", 32'(c_req), 32'd1);
      next();
      c_ack = 1'b0;
      #2;
      chk("stall_r1_done",  32'(r1_done), 32'd1);
      chk("stall_r1_rdata", r1_rdata,     32'd444);
      chk("stall_done_r0_gnt", 32'(r0_gnt), 32'd0);
      next();
      #2;
      chk("stall_r1_done_once", 32'(r1_done), 32'd0);
      chk("stall_r0_gnt_after", 32'(r0_gnt),  32'd1);
      next();
      r0_req = 1'b0; c_ack = 1'b1;
      next();
      c_ack = 1'b0;
      next();

      // ---------------- timeout, no ack ----------------
      r0_req = 1'b1; r0_op = 1'b0; r0_addr = 32'd128; c_rdata = 32'd57005;
      #2;
      chk("to_r0_gnt", 32'(r0_gnt), 32'd1);
      next();
      r0_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #2;
         chk("to_c_req",   32'(c_req),   32'd1);
         chk("to_r0_done", 32'(r0_done), 32'd0);
         next();
      end
      #2;
      chk("to_c_req_drop", 32'(c_req),   32'd0);
      chk("to_done",       32'(r0_done), 32'd1);
      chk("to_err",        32'(r0_err),  32'd1);
      chk("to_rdata",      r0_rdata,     32'd0);
      chk("to_r1_done",    32'(r1_done), 32'd0);
      next();
      r0_req = 1'b1;
      #2;
      chk("to_done_clear", 32'(r0_done), 32'd0);
      chk("to_err_clear",  32'(r0_err),  32'd0);
      chk("to_idle_gnt",   32'(r0_gnt),  32'd1);

      // ---------------- ack on the final allowed cycle ----------------
      next();
      r0_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #2;
         chk("to8_c_req", 32'(c_req), 32'd1);
         next();
      end
      c_ack = 1'b1; c_rdata = 32'd555;
      #2;
      chk("to8_c_req_last", 32'(c_req), 32'd1);
      next();
      c_ack = 1'b0;
      #2;
      chk("to8_done",  32'(r0_done), 32'd1);
      chk("to8_err",   32'(r0_err),  32'd0);
      chk("to8_rdata", r0_rdata,     32'd555);
      next();

      // ---------------- fairness ----------------
      rst = 1'b1;
      next();
      rst = 1'b0;
      r0_req = 1'b1; r0_op = 1'b0; r0_addr = 32'd256;
      r1_req = 1'b1; r1_op = 1'b0; r1_addr = 32'd512;
      for (int k = 0; k < 6; k++) begin
         #2;
         chk("fair_r0_gnt", 32'(r0_gnt), 32'(k % 2 == 0));
         chk("fair_r1_gnt", 32'(r1_gnt), 32'(k % 2 == 1));
         next();
         c_ack = 1'b1; c_rdata = 32'(1000 + k);
         #2;
         chk("fair_c_addr", c_addr, (k % 2 == 0) ? 32'd256 : 32'd512);
         next();
         c_ack = 1'b0;
         #2;
         chk("fair_r0_done", 32'(r0_done), 32'(k % 2 == 0));
         chk("fair_r1_done", 32'(r1_done), 32'(k % 2 == 1));
         chk("fair_rdata", (k % 2 == 0) ? r0_rdata : r1_rdata, 32'(1000 + k));
         next();
      end
      r0_req = 1'b0; r1_req = 1'b0;

      // ---------------- reset mid-BUSY ----------------
      r0_req = 1'b1; r0_addr = 32'd64;
      #2;
      chk("mrst_r0_gnt", 32'(r0_gnt), 32'd1);
      next();
      r0_req = 1'b0;
      #2;
      chk("mrst_c_req_a", 32'(c_req), 32'd1);
      next();
      #2;
      chk("mrst_c_req_b", 32'(c_req), 32'd1);
      rst = 1'b1;
      next();
      rst = 1'b0;
      #2;
      chk("mrst_c_req_drop", 32'(c_req),   32'd0);
      chk("mrst_no_done",    32'(r0_done), 32'd0);
      chk("mrst_no_err",     32'(r0_err),  32'd0);
      r0_req = 1'b1; r1_req = 1'b1;
      #1;
      chk("mrst_tie_r0_gnt", 32'(r0_gnt), 32'd1);
      chk("mrst_tie_r1_gnt", 32'(r1_gnt), 32'd0);
      next();
      r0_req = 1'b0; r1_req = 1'b0; c_ack = 1'b1; c_rdata = 32'd777;
      next();
      c_ack = 1'b0;
      #2;
      chk("mrst_done_after", 32'(r0_done), 32'd1);
      chk("mrst_rdata_after", r0_rdata,    32'd777);
      next();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Shares the single-ported 4-way set-associative cache controller between two requesters: port 0 (fetch side) and port 1 (load/store side).
- Arbitrates round-robin and keeps at most one transaction outstanding to the cache.
- Holds the command stable until the cache acknowledges, then routes read data back to the winning port.
- Aborts with an error pulse if the cache does not acknowledge within TIMEOUT cycles.

Parameters:
- ADDR_W, 32, address width (tag 31:10, set index 9:2).
- DATA_W, 32, data word width.
- TIMEOUT, 64, maximum number of BUSY cycles waited for c_ack before abort (legal range 2..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- r0_req  in  1  port 0 request; held with fields stable until r0_gnt.
- r0_op  in  1  0 = read, 1 = write.
- r0_addr  in  ADDR_W  port 0 byte address.
- r0_wdata  in  DATA_W  port 0 write data.
- r0_gnt  out  1  port 0 request accepted this cycle (combinational, IDLE only).
- r0_done  out  1  one-cycle completion pulse to port 0.
- r0_err  out  1  qualifies r0_done; 1 = timeout abort.
- r0_rdata  out  DATA_W  read data; valid only while r0_done=1.
- r1_req, r1_op, r1_addr, r1_wdata, r1_gnt, r1_done, r1_err, r1_rdata: identical definitions for port 1.
- c_req  out  1  command valid to cache controller (registered).
- c_op  out  1  latched op.
- c_addr  out  ADDR_W  latched address.
- c_wdata  out  DATA_W  latched write data.
- c_ack  in  1  cache has completed the command (read data valid this cycle).
- c_rdata  in  DATA_W  cache read data.

Behaviour:
- FSM states are IDLE, BUSY and DONE. The reset state is IDLE.
- Reset values:
  - c_req, all gnt/done/err signals: 0.
  - c_op, c_addr, c_wdata, rdata registers: 0.
  - Priority pointer: port 0. Timeout counter: 0.
- IDLE:
  - If any req is high, grant exactly one: the single requester, or on a tie the port named by the priority pointer.
  - rN_gnt is high in that same cycle. At the edge, latch op/addr/wdata and owner, set the pointer to the other port, and go to BUSY.
  - With no request, stay in IDLE and keep gnt low.
- BUSY:
  - c_req=1; c_op/c_addr/c_wdata hold the latched values unchanged.
  - Timeout counter clears on entry and increments each BUSY cycle with c_ack=0.
  - c_ack=1: capture c_rdata (0 if op was write), set err=0, go to DONE.
  - Counter = TIMEOUT-1 with c_ack=0: rdata=0, err=1, go to DONE.
  - c_ack coinciding with that timeout cycle: ack wins, err=0.
- DONE:
  - c_req=0; r{owner}_done=1 for exactly one cycle, with rdata/err driven; the non-owner port's done/err/rdata stay 0.
  - No grant is issued in DONE. Next state is IDLE.
- Minimum turnaround: request accepted cycle 0, c_req in cycle 1, ack in cycle 1, done in cycle 2, next grant in cycle 3.
- c_ack outside BUSY is ignored. A requester dropping req before gnt withdraws the request with no side effect.
- Back-to-back requests from both ports alternate strictly 0,1,0,1 when both are held high continuously.
- A write that hits in the cache completes like a read, with done=1 and rdata=0.
- rst asserted in any state: at the next edge return to IDLE.
  - c_req drops, no done/err pulse for the aborted transaction, pointer returns to port 0.
  - rst has priority over every other event in that cycle.

Test Plan:
- Single read: r0 read addr=64; cache acks 1 cycle after c_req with 111 -> r0_gnt in cycle 0, c_req cycle 1 with c_addr=64, r0_done=1/r0_rdata=111/r0_err=0 in cycle 2, r1 outputs 0.
- Simultaneous requests after reset: r0 write addr=1088 data=222 and r1 read addr=3136 -> r0 granted first with c_wdata=222, r1 granted in the first IDLE after r0_done, pointer back to port 0 afterwards.
- Stall hold: c_ack delayed 5 cycles on r1 read addr=7232 -> c_req and c_addr=7232 stay stable for 5 cycles, r1_done exactly one cycle after ack, no grant issued meanwhile.
- Timeout: TIMEOUT=8, c_ack held 0 -> c_req high 8 cycles, r0_done=1/r0_err=1/r0_rdata=0, FSM returns to IDLE; repeat with ack on cycle 8 -> err=0.
- Fairness: both reqs held high 6 transactions, each immediate ack -> grant order 0,1,0,1,0,1, each done routed to the correct port.
- Reset mid-BUSY: assert rst for 1 cycle during a stalled read -> c_req=0 next cycle, no done pulse, a later tie grants port 0 first.
